// File: rtl/uart_pkg.sv
// UART shared definitions: sequencer state encoding and default frame geometry.
// Imported by both the receive and the transmit sequencers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sequencer_if.sv
// Receive-side consumer bundle: word, valid/ready handshake, error pulses.
// master = sequencer (drives word/flags), slave = consumer (drives rx_ready).
interface uart_rx_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] rx;
  logic             rx_valid;
  logic             rx_ready;
  logic             frame_err;
  logic             overrun;

  modport master (
    output rx, rx_valid, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx, rx_valid, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_sequencer_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports: clk, reset (sync, active-high), d (async in), q (synchronized out).
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive control FSM: start qualify, mid-bit sampling, stop check.
// Ports: clk, reset, baud tick, data line, busy; bus = word/handshake/flags.
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  input  logic baud,
  input  logic data,
  output logic busy,
  uart_rx_sequencer_if.master bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [TW-1:0] MID   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);

  logic sd;

  uart_state_e      state_q;
  logic [TW-1:0]    tick_q;
  logic [BW-1:0]    bit_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] rx_q;
  logic             rx_valid_q;
  logic             frame_err_q;
  logic             overrun_q;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (data),
    .q     (sd)
  );

  always_ff @(posedge clk) begin
    frame_err_q <= 1'b0;
    overrun_q   <= 1'b0;
    if (rx_valid_q && bus.rx_ready) begin
      rx_valid_q <= 1'b0;
    end
    if (reset) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_q       <= '0;
      rx_valid_q <= 1'b0;
    end else if (baud) begin
      unique case (state_q)
        IDLE: begin
          if (!sd) begin
            state_q <= START;
            tick_q  <= '0;
          end
        end
        START: begin
          if (tick_q == MID) begin
            tick_q  <= '0;
            bit_q   <= '0;
            // high at mid-start means a glitch, not a frame
            state_q <= sd ? IDLE : DATA;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        DATA: begin
          if (tick_q == LAST) begin
            tick_q  <= '0;
            shift_q <= {sd, shift_q[WIDTH-1:1]};
            if (bit_q == BLAST) begin
              bit_q   <= '0;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        STOP: begin
          if (tick_q == LAST) begin
            tick_q <= '0;
            if (!sd) begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end else begin
              state_q <= IDLE;
              // a word being accepted this cycle frees the slot
              if (!rx_valid_q || bus.rx_ready) begin
                rx_q       <= shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        BREAK: begin
          if (sd) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign bus.rx        = rx_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer: 8N1, 16x oversample, baud every 4 clk.
// Inputs change 2 time units after posedge; outputs sampled on negedge.
module tb_uart_rx_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic baud = 1'b0;
  logic data = 1'b1;
  logic busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  int acc_cnt  = 0;
  int vcyc     = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int bcyc     = 0;
  logic [7:0] last_acc = 8'h00;

  int bcnt = 0;

  uart_rx_sequencer_if #(.WIDTH(8)) bus ();

  uart_rx_sequencer #(
    .WIDTH      (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .baud  (baud),
    .data  (data),
    .busy  (busy),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    bcnt = (bcnt + 1) % 4;
    baud = (bcnt == 0);
  end

  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready) begin
      acc_cnt++;
      last_acc = bus.rx;
    end
    if (bus.rx_valid)  vcyc++;
    if (bus.frame_err) ferr_cnt++;
    if (bus.overrun)   ovr_cnt++;
    if (busy)          bcyc++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    data = 1'b0;
    step(64);
    for (int i = 0; i < 8; i++) begin
      data = b[i];
      step(64);
    end
    data = stop;
    step(64);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rx_ready = 1'b1;
    step(3);
    chk_cnt++;
    if (bus.rx !== 8'h00)
      $display("FAIL reset_rx got %h want 00", bus.rx);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.rx_valid, bus.frame_err, bus.overrun, busy} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000",
               {bus.rx_valid, bus.frame_err, bus.overrun, busy});
    else pass_cnt++;
    reset = 1'b0;
    step(20);
  endtask

  task automatic test_frame();
    int a0, v0, f0;
    a0 = acc_cnt; v0 = vcyc; f0 = ferr_cnt;
    bus.rx_ready = 1'b1;
    send_frame(8'h59, 1'b1);
    step(10);
    chk_cnt++;
    if (acc_cnt - a0 !== 1 || last_acc !== 8'h59)
      $display("FAIL frame_word got n=%0d %h want n=1 59",
               acc_cnt - a0, last_acc);
    else pass_cnt++;
    chk_cnt++;
    if (vcyc - v0 !== 1)
      $display("FAIL frame_valid_cycles got %0d want 1", vcyc - v0);
    else pass_cnt++;
    chk_cnt++;
    if (ferr_cnt - f0 !== 0 || busy !== 1'b0 || bus.rx !== 8'h59)
      $display("FAIL frame_after got ferr=%0d busy=%b rx=%h want 0 0 59",
               ferr_cnt - f0, busy, bus.rx);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    int a0, f0, o0, b0;
    a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt; b0 = bcyc;
    data = 1'b0;
    step(16);
    data = 1'b1;
    step(100);
    chk_cnt++;
    if (bcyc - b0 < 1 || busy !== 1'b0)
      $display("FAIL glitch_busy got cyc=%0d busy=%b want >0 0",
               bcyc - b0, busy);
    else pass_cnt++;
    chk_cnt++;
    if (acc_cnt - a0 !== 0 || ferr_cnt - f0 !== 0 || ovr_cnt - o0 !== 0)
      $display("FAIL glitch_quiet got w=%0d f=%0d o=%0d want 0 0 0",
               acc_cnt - a0, ferr_cnt - f0, ovr_cnt - o0);
    else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int a0, f0;
    a0 = acc_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0);
    step(200);
    chk_cnt++;
    if (ferr_cnt - f0 !== 1 || acc_cnt - a0 !== 0 || bus.rx_valid !== 1'b0)
      $display("FAIL ferr_pulse got f=%0d w=%0d v=%b want 1 0 0",
               ferr_cnt - f0, acc_cnt - a0, bus.rx_valid);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b1)
      $display("FAIL ferr_break_busy got %b want 1", busy);
    else pass_cnt++;
    data = 1'b1;
    step(30);
    chk_cnt++;
    if (busy !== 1'b0)
      $display("FAIL ferr_break_exit got %b want 0", busy);
    else pass_cnt++;
    send_frame(8'h3C, 1'b1);
    step(10);
    chk_cnt++;
    if (acc_cnt - a0 !== 1 || last_acc !== 8'h3C)
      $display("FAIL ferr_next_word got n=%0d %h want n=1 3C",
               acc_cnt - a0, last_acc);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int a0, o0;
    a0 = acc_cnt; o0 = ovr_cnt;
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    step(10);
    chk_cnt++;
    if (bus.rx_valid !== 1'b1 || bus.rx !== 8'h11)
      $display("FAIL ovr_first got v=%b rx=%h want 1 11",
               bus.rx_valid, bus.rx);
    else pass_cnt++;
    send_frame(8'h22, 1'b1);
    step(10);
    chk_cnt++;
    if (ovr_cnt - o0 !== 1 || bus.rx !== 8'h11 || bus.rx_valid !== 1'b1)
      $display("FAIL ovr_pulse got o=%0d rx=%h v=%b want 1 11 1",
               ovr_cnt - o0, bus.rx, bus.rx_valid);
    else pass_cnt++;
    bus.rx_ready = 1'b1;
    step(2);
    chk_cnt++;
    if (bus.rx_valid !== 1'b0)
      $display("FAIL ovr_drain got v=%b want 0", bus.rx_valid);
    else pass_cnt++;
    step(200);
    chk_cnt++;
    if (acc_cnt - a0 !== 1 || last_acc !== 8'h11)
      $display("FAIL ovr_no_22 got n=%0d %h want n=1 11",
               acc_cnt - a0, last_acc);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int a0, o0, k;
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    step(10);
    a0 = acc_cnt; o0 = ovr_cnt;
    fork
      send_frame(8'h22, 1'b1);
      begin
        k = 0;
        while (busy !== 1'b1 && k < 2000) begin
          step(1);
          k++;
        end
        chk_cnt++;
        if (k >= 2000)
          $display("FAIL b2b_start_timeout got busy=%b want 1", busy);
        else pass_cnt++;
        // start detect edge + 152 baud ticks (608 clk) = stop sample edge
        step(607);
        bus.rx_ready = 1'b1;
        step(1);
        bus.rx_ready = 1'b0;
      end
    join
    step(5);
    chk_cnt++;
    if (acc_cnt - a0 !== 1 || last_acc !== 8'h11)
      $display("FAIL b2b_consume got n=%0d %h want n=1 11",
               acc_cnt - a0, last_acc);
    else pass_cnt++;
    chk_cnt++;
    if (bus.rx !== 8'h22 || bus.rx_valid !== 1'b1 || ovr_cnt - o0 !== 0)
      $display("FAIL b2b_load got rx=%h v=%b o=%0d want 22 1 0",
               bus.rx, bus.rx_valid, ovr_cnt - o0);
    else pass_cnt++;
    bus.rx_ready = 1'b1;
    step(2);
    chk_cnt++;
    if (bus.rx_valid !== 1'b0 || last_acc !== 8'h22)
      $display("FAIL b2b_drain got v=%b %h want 0 22",
               bus.rx_valid, last_acc);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int a0, f0;
    bus.rx_ready = 1'b0;
    send_frame(8'h81, 1'b1);
    step(10);
    data = 1'b0;
    step(64);
    data = 1'b1;
    step(64 * 4 + 32);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_cnt++;
    if (bus.rx !== 8'h00 || bus.rx_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL mreset_out got rx=%h v=%b busy=%b want 00 0 0",
               bus.rx, bus.rx_valid, busy);
    else pass_cnt++;
    a0 = acc_cnt; f0 = ferr_cnt;
    bus.rx_ready = 1'b1;
    step(64 * 5);
    send_frame(8'h0F, 1'b1);
    step(10);
    chk_cnt++;
    if (acc_cnt - a0 !== 1 || last_acc !== 8'h0F || ferr_cnt - f0 !== 0)
      $display("FAIL mreset_next got n=%0d %h f=%0d want n=1 0F 0",
               acc_cnt - a0, last_acc, ferr_cnt - f0);
    else pass_cnt++;
  endtask

  initial begin
    bus.rx_ready = 1'b1;
    test_reset();
    test_frame();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_sequencer.md
Name: uart_rx_sequencer

Overview:
- Control FSM for the UART receive path.
- Oversamples the asynchronous serial line using the baud-unit tick.
- Detects and qualifies start bits, samples data bits mid-bit (LSB first) and checks the stop bit.
- Presents each received word through a one-entry valid/ready holding register, with framing-error and overrun flags; sits between the baud generator and downstream consumers.

Parameters:
- WIDTH, 8: data bits per frame.
- OVERSAMPLE, 16: baud ticks per bit period; even, at least 4.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- baud  input  1  one-clk-wide tick at OVERSAMPLE x bit rate; all bit timing advances only on cycles with baud=1.
- data  input  1  asynchronous serial line; idle high.
- rx  output  WIDTH  received word (holding register).
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts when rx_valid && rx_ready.
- frame_err  output  1  one-clk pulse: stop bit sampled low.
- overrun  output  1  one-clk pulse: good frame dropped because holding register full.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Input synchronizer:
  - data passes through a 2-flop synchronizer; both flops reset to 1.
  - All FSM decisions use the synchronized value sd; data-to-sd latency is 2 clk.
- Reset:
  - state=IDLE; tick counter=0; bit counter=0; shift register=0; rx=0.
  - rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset asserted mid-frame aborts the frame and discards partial data; rx_valid is cleared even if unconsumed.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- Tick counter: 0..OVERSAMPLE-1, increments only when baud=1.
- IDLE:
  - On baud=1 with sd=0: go to START, tick counter=0.
- START:
  - When baud=1 and tick counter=OVERSAMPLE/2-1 (mid-bit), sample sd.
  - sd=1: glitch; return to IDLE, no flags.
  - sd=0: go to DATA; tick counter=0, bit counter=0.
- DATA:
  - When baud=1 and tick counter=OVERSAMPLE-1, sample sd into shift register MSB, shifting right (LSB-first reception); tick counter wraps to 0.
  - After the WIDTH-th sample (bit counter=WIDTH-1), go to STOP.
- STOP:
  - When baud=1 and tick counter=OVERSAMPLE-1, sample sd.
  - sd=1 and holding register free, or being accepted this same cycle: rx<=shift register, rx_valid<=1; go to IDLE.
  - sd=1 and rx_valid=1 with rx_ready=0: rx unchanged; overrun pulses 1 clk; go to IDLE.
  - sd=0: frame_err pulses 1 clk; nothing loaded; go to BREAK.
- BREAK:
  - Stay until a baud tick with sd=1, then go to IDLE. This prevents a held-low line from retriggering start.
- Holding register:
  - rx_valid clears on the cycle after rx_valid && rx_ready.
  - Load and accept in the same cycle: new word loaded, rx_valid stays 1.
  - rx is stable while rx_valid=1 and not accepted.
- Latency: rx_valid rises 1 clk after the stop-bit sample tick.
- baud held low freezes the FSM and counters; rx_ready handshakes remain live.

Decomposition:
- Shared package uart_pkg: state enum constants (IDLE, START, DATA, STOP, BREAK) and default WIDTH/OVERSAMPLE localparams, shared with the transmit sequencer.
- One natural sub-module: sync2 (2-flop synchronizer, reset value parameterized to 1).
- FSM, counters and holding register stay in the top module.

Test Plan (WIDTH=8, OVERSAMPLE=16, baud every 4 clk, so 1 bit = 64 clk):
1. Send frame 0x59 (start 0, bits 1,0,0,1,1,0,1,0, stop 1), rx_ready=1 -> rx=8'h59, rx_valid pulses 1 clk, frame_err=0, busy low after stop.
2. data low for only 16 clk (4 ticks) then high -> return to IDLE at mid-start sample; no rx_valid, no flags.
3. Send 0xA5 with stop bit 0, line then held low 200 clk -> frame_err single pulse, rx_valid=0, FSM in BREAK until line high; a following 0x3C frame is received correctly.
4. rx_ready=0; send 0x11 then 0x22 -> rx=8'h11 held, overrun pulses at the second stop sample; after rx_ready=1, rx_valid clears and no 0x22 appears.
5. rx_ready asserted exactly on the cycle 0x22 loads (0x11 pending) -> 0x11 consumed, rx=8'h22, rx_valid stays 1, overrun=0.
6. reset asserted for 1 clk after the 4th data bit of 0xFF -> all outputs at reset values next clk; a subsequent 0x0F frame is received correctly.
